// File: rtl/mainfsm_pkg.sv
// Shared definitions for the multi-cycle main control FSM: state encoding,
// datapath mux select codes and the decoded control word.
package mainfsm_pkg;

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecuteR = 4'd6,
      StExecuteI = 4'd7,
      StAluWb    = 4'd8,
      StBranch   = 4'd9,
      StMulWbHi  = 4'd10
   } state_e;

   localparam logic [1:0] SrcAReg      = 2'b00;
   localparam logic [1:0] SrcAPc       = 2'b01;
   localparam logic [1:0] SrcBReg      = 2'b00;
   localparam logic [1:0] SrcBImm      = 2'b01;
   localparam logic [1:0] SrcBFour     = 2'b10;
   localparam logic [1:0] ResAluOut    = 2'b00;
   localparam logic [1:0] ResData      = 2'b01;
   localparam logic [1:0] ResAluResult = 2'b10;

   typedef struct packed {
      logic       ir_write;
      logic       next_pc;
      logic       reg_w;
      logic       reg_w_hi;
      logic       mem_w;
      logic       branch;
      logic       adr_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic       alu_op;
   } ctrl_t;

endpackage

// File: rtl/mainfsm_outdec.sv
// Combinational state-to-control-word decoder (Moore outputs of mainfsm).
module mainfsm_outdec
   import mainfsm_pkg::*;
(
   input  state_e state,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         StFetch: begin
            ctrl.ir_write   = 1'b1;
            ctrl.next_pc    = 1'b1;
            ctrl.alu_src_a  = SrcAPc;
            ctrl.alu_src_b  = SrcBFour;
            ctrl.result_src = ResAluResult;
         end
         StDecode: begin
            ctrl.alu_src_a  = SrcAPc;
            ctrl.alu_src_b  = SrcBFour;
            ctrl.result_src = ResAluResult;
         end
         StMemAdr:   ctrl.alu_src_b = SrcBImm;
         StMemRead:  ctrl.adr_src = 1'b1;
         StMemWb: begin
            ctrl.result_src = ResData;
            ctrl.reg_w      = 1'b1;
         end
         StMemWrite: begin
            ctrl.adr_src = 1'b1;
            ctrl.mem_w   = 1'b1;
         end
         StExecuteR: ctrl.alu_op = 1'b1;
         StExecuteI: begin
            ctrl.alu_src_b = SrcBImm;
            ctrl.alu_op    = 1'b1;
         end
         StAluWb:    ctrl.reg_w = 1'b1;
         StMulWbHi: begin
            ctrl.reg_w_hi   = 1'b1;
            ctrl.result_src = ResAluOut;
         end
         StBranch: begin
            ctrl.alu_src_b  = SrcBImm;
            ctrl.result_src = ResAluResult;
            ctrl.branch     = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mainfsm.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives unconditioned enables plus datapath mux selects.
module mainfsm
   import mainfsm_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic       LongMul,
   output logic       IRWrite,
   output logic       NextPC,
   output logic       RegW,
   output logic       RegWHi,
   output logic       MemW,
   output logic       Branch,
   output logic       AdrSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       ALUOp,
   output logic [3:0] State
);

   state_e state_q, state_d;
   logic   mull_q, mull_d;
   ctrl_t  ctrl;
   logic   unused_funct;

   assign unused_funct = ^Funct[4:1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StFetch;
         mull_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mull_q  <= mull_d;
      end
   end

   always_comb begin
      state_d = StFetch;
      mull_d  = mull_q;
      case (state_q)
         StFetch: state_d = StDecode;
         StDecode: begin
            // Only a register-form data-processing op can be a long multiply.
            mull_d = (Op == 2'b00) && !Funct[5] && LongMul;
            case (Op)
               2'b01:   state_d = StMemAdr;
               2'b10:   state_d = StBranch;
               2'b00:   state_d = Funct[5] ? StExecuteI : StExecuteR;
               default: state_d = StFetch;
            endcase
         end
         StMemAdr:   state_d = Funct[0] ? StMemRead : StMemWrite;
         StMemRead:  state_d = StMemWb;
         StExecuteR: state_d = StAluWb;
         StExecuteI: state_d = StAluWb;
         StAluWb:    state_d = mull_q ? StMulWbHi : StFetch;
         StMulWbHi: begin
            mull_d  = 1'b0;
            state_d = StFetch;
         end
         default:    state_d = StFetch;
      endcase
   end

   mainfsm_outdec u_outdec (
      .state (state_q),
      .ctrl  (ctrl)
   );

   always_comb begin
      IRWrite   = ctrl.ir_write;
      NextPC    = ctrl.next_pc;
      RegW      = ctrl.reg_w;
      RegWHi    = ctrl.reg_w_hi;
      MemW      = ctrl.mem_w;
      Branch    = ctrl.branch;
      AdrSrc    = ctrl.adr_src;
      ALUSrcA   = ctrl.alu_src_a;
      ALUSrcB   = ctrl.alu_src_b;
      ResultSrc = ctrl.result_src;
      ALUOp     = ctrl.alu_op;
      State     = state_q;
   end

endmodule

// File: tb/tb_mainfsm.sv
// Scoreboard bench for mainfsm: a reference model expands each instruction into
// its expected per-cycle control words; a monitor compares them every cycle.
module tb_mainfsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       LongMul;
   logic       IRWrite, NextPC, RegW, RegWHi, MemW, Branch, AdrSrc, ALUOp;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
   logic [3:0] State;

   int n_vec = 0;
   int n_err = 0;
   int mem_writes = 0;
   int exp_stores = 0;
   bit mon_en = 1'b0;
   logic [17:0] exp_q[$];

   mainfsm dut (
      .clk       (clk),
      .reset     (reset),
      .Op        (Op),
      .Funct     (Funct),
      .LongMul   (LongMul),
      .IRWrite   (IRWrite),
      .NextPC    (NextPC),
      .RegW      (RegW),
      .RegWHi    (RegWHi),
      .MemW      (MemW),
      .Branch    (Branch),
      .AdrSrc    (AdrSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ResultSrc (ResultSrc),
      .ALUOp     (ALUOp),
      .State     (State)
   );

   always #5 clk = ~clk;

   // Field order: state, IRWrite, NextPC, RegW, RegWHi, MemW, Branch, AdrSrc,
   // ALUSrcA, ALUSrcB, ResultSrc, ALUOp.
   function automatic logic [17:0] actual();
      return {State, IRWrite, NextPC, RegW, RegWHi, MemW, Branch, AdrSrc,
              ALUSrcA, ALUSrcB, ResultSrc, ALUOp};
   endfunction

   // Control table straight from the state descriptions.
   function automatic logic [17:0] exp_word(int s);
      logic [3:0] st;
      logic irw, npc, rw, rwh, mw, br, adr, aop;
      logic [1:0] sa, sb, rs;
      st = 4'(s);
      {irw, npc, rw, rwh, mw, br, adr, aop} = '0;
      sa = 2'b00; sb = 2'b00; rs = 2'b00;
      case (s)
         0:  begin irw = 1; npc = 1; sa = 2'b01; sb = 2'b10; rs = 2'b10; end
         1:  begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
         2:  sb = 2'b01;
         3:  adr = 1;
         4:  begin rs = 2'b01; rw = 1; end
         5:  begin adr = 1; mw = 1; end
         6:  aop = 1;
         7:  begin sb = 2'b01; aop = 1; end
         8:  rw = 1;
         9:  begin sb = 2'b01; rs = 2'b10; br = 1; end
         10: rwh = 1;
         default: ;
      endcase
      return {st, irw, npc, rw, rwh, mw, br, adr, sa, sb, rs, aop};
   endfunction

   // Expected state walk of one instruction, FETCH up to just before the next FETCH.
   task automatic push_instr(input logic [1:0] op, input logic [5:0] f, input logic lm,
                             output int len);
      int seq[$];
      seq = '{0, 1};
      case (op)
         2'b01: if (f[0]) seq = {seq, 2, 3, 4};
                else begin seq = {seq, 2, 5}; exp_stores++; end
         2'b10: seq.push_back(9);
         2'b00: begin
            seq.push_back(f[5] ? 7 : 6);
            seq.push_back(8);
            if (lm && !f[5]) seq.push_back(10);
         end
         default: ;
      endcase
      foreach (seq[i]) exp_q.push_back(exp_word(seq[i]));
      len = seq.size();
   endtask

   task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h (state %0d) want %h (state %0d)",
                  name, act, act[17:14], exp, exp[17:14]);
      end
   endtask

   task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input logic lm);
      int len;
      Op = op; Funct = f; LongMul = lm;
      push_instr(op, f, lm, len);
      mon_en = 1'b1;
      repeat (len) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() == 0) check("queue_underflow", actual(), 18'h3ffff);
         else check("cycle", actual(), exp_q.pop_front());
      end
   end

   always @(posedge clk) if (!reset && MemW) mem_writes++;

   initial begin
      int len;
      reset = 1'b1; Op = 2'b11; Funct = '0; LongMul = 1'b0;
      #2;
      repeat (3) begin
         @(negedge clk);
         check("reset_hold", actual(), exp_word(0));
      end
      @(posedge clk); #1;
      reset = 1'b0;
      run_instr(2'b11, 6'h00, 1'b0);
      run_instr(2'b11, 6'h00, 1'b0);
      run_instr(2'b00, 6'b001000, 1'b0);   // ADD reg
      run_instr(2'b01, 6'b011001, 1'b0);   // LDR
      run_instr(2'b01, 6'b011000, 1'b0);   // STR
      run_instr(2'b10, 6'b000000, 1'b0);   // B
      run_instr(2'b00, 6'b000001, 1'b1);   // long multiply
      run_instr(2'b00, 6'b100001, 1'b1);   // LongMul ignored with I=1
      run_instr(2'b01, 6'b000001, 1'b1);   // LongMul ignored on memory path
      run_instr(2'b00, 6'b000000, 1'b0);   // ensure no stale mull_q
      for (int i = 0; i < 200; i++)
         run_instr(2'($urandom_range(0, 3)), 6'($urandom), 1'($urandom));

      // Store interrupted by a reset pulse while in MEMWRITE.
      Op = 2'b01; Funct = 6'b000000; LongMul = 1'b0;
      exp_q.push_back(exp_word(0));
      exp_q.push_back(exp_word(1));
      exp_q.push_back(exp_word(2));
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1'b0;
      #1;
      check("pre_reset_memwrite", actual(), exp_word(5));
      #1 reset = 1'b1;
      #1 check("async_reset", actual(), exp_word(0));
      #1 reset = 1'b0;
      Op = 2'b11;
      exp_q.push_back(exp_word(1));
      @(posedge clk); #1;
      mon_en = 1'b1;
      @(posedge clk); #1;
      run_instr(2'b10, 6'h00, 1'b0);
      run_instr(2'b00, 6'b100000, 1'b0);
      mon_en = 1'b0;
      n_vec++;
      if (mem_writes != exp_stores) begin
         n_err++;
         $display("FAIL mem_write_count: got %0d want %0d", mem_writes, exp_stores);
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL queue_leftover: got %0d want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mainfsm.md
# mainfsm

Multi-cycle main control FSM for the processor's control unit. Sequences each instruction through fetch, decode, execute, memory and writeback cycles, driving the datapath mux selects directly. It also produces the unconditioned enables NextPC, RegW, MemW, Branch and RegWHi, which the condition-logic stage qualifies with the condition result before they reach the PC, register file and memory. Flag-write enables are produced elsewhere and are not part of this block.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces the state to FETCH.
- Op  in  2  instruction bits [27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
- Funct  in  6  instruction bits [25:20]; bit 5 is I (immediate), bit 0 is L/S.
- LongMul  in  1  from the instruction decoder: the current instruction is a 64-bit multiply that writes a high-word destination.
- IRWrite  out  1  instruction register load.
- NextPC  out  1  PC update request (unconditional at this stage).
- RegW  out  1  register-file write request, low word.
- RegWHi  out  1  register-file write request, high word.
- MemW  out  1  memory write request.
- Branch  out  1  branch cycle marker.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result.
- ALUSrcA  out  2  ALU A select: 00 = register A, 01 = PC.
- ALUSrcB  out  2  ALU B select: 00 = register B, 01 = ExtImm, 10 = constant 4.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUOp  out  1  0 = force add, 1 = decode from Funct.
- State  out  4  current state encoding, for debug and the testbench.

## Operation
States and outputs are Moore. Any output not listed for a state is 0.
- FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next state: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Latches LongMul into an internal flag `mull_q`. Next state:
  - Op=01: MEMADR.
  - Op=10: BRANCH.
  - Op=00 with Funct[5]=1: EXECUTEI.
  - Op=00 with Funct[5]=0: EXECUTER.
  - Op=11: FETCH (treated as a NOP).
- MEMADR: ALUSrcB=01. Next state: MEMREAD if Funct[0]=1, else MEMWRITE.
- MEMREAD: AdrSrc=1. Next state: MEMWB.
- MEMWB: ResultSrc=01, RegW=1. Next state: FETCH.
- MEMWRITE: AdrSrc=1, MemW=1. Next state: FETCH.
- EXECUTER: ALUOp=1. Next state: ALUWB.
- EXECUTEI: ALUSrcB=01, ALUOp=1. Next state: ALUWB.
- ALUWB: RegW=1. Next state: MULWBHI if `mull_q`=1, else FETCH.
- MULWBHI: RegWHi=1, ResultSrc=00. Clears `mull_q`. Next state: FETCH.
- BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1. Next state: FETCH.

Rules and boundary cases:
- LongMul is sampled only in DECODE, and only when Op=00 and Funct[5]=0. It is ignored on every other path, so `mull_q` is 0 for them.
- An unused state encoding drives all outputs to 0 and goes to FETCH on the next edge.
- `mull_q` resets to 0.

## Timing
- Reset:
  - Asynchronous assertion sets State=FETCH and `mull_q`=0 immediately.
  - While reset is held, outputs show FETCH values: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, everything else 0. The datapath registers are also held in reset, so these values have no effect.
  - The first rising edge after deassertion moves to DECODE.
- Reset mid-instruction abandons the sequence with no partial writes. Any enable high at that moment drops within the same cycle.
- Cycles per instruction (FETCH through return to FETCH):
  - Branch: 3.
  - Store: 4.
  - Data-processing: 4.
  - Load: 5.
  - Long multiply: 5.
  - Op=11: 2.
- All outputs are purely combinational from the state registers. No input-to-output combinational path exists except through the registered state.
- Op, Funct and LongMul must be stable in the cycle after IRWrite, i.e. they come from the instruction register.

## Structure
- Shared control package holds:
  - the state enum, 4 bits: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, MULWBHI=10;
  - named constants for the ALUSrcA, ALUSrcB and ResultSrc codes.
- One natural sub-module, `mainfsm_outdec`: a combinational state-to-control-word decoder.
- The state register and `mull_q` stay in the top level.

## Test plan
- Reset held for 3 cycles, then released:
  - During reset, State=0, IRWrite=1, NextPC=1, all writes 0.
  - After release, State walks 1, 0, 1 with Op=11.
- ADD register form (Op=00, Funct=001000, LongMul=0):
  - States 0→1→6→8→0.
  - RegW=1 only in state 8.
  - ALUOp=1 only in state 6.
- LDR (Op=01, Funct[0]=1): states 0→1→2→3→4→0; AdrSrc=1 in state 3; ResultSrc=01 with RegW=1 in state 4.
- STR (Op=01, Funct[0]=0): states 0→1→2→5→0; MemW=1 for exactly one cycle. Then B (Op=10): states 0→1→9→0 with Branch=1.
- Long multiply:
  - With LongMul=1 (Op=00, Funct[5]=0): states 0→1→6→8→10→0; RegW in state 8, RegWHi in state 10.
  - With LongMul=1 but Funct[5]=1: state 10 never entered.
- Asynchronous reset pulse mid-cycle while in MEMWRITE: MemW falls immediately, State=0, and no memory write is recorded.
